i2s_rx_deser: RTL and testbench

I2S receive deserializer running in the I2S bit-clock domain (1.4112 MHz = 44.1 kHz × 2 channels × 16 bits). It samples the serial data and word-select lines, assembles 16-bit two's-complement samples per channel, and emits one-cycle valid pulses with held data. It sits directly upstream of the slow-to-fast CDC FIFO, driving its `pkt_i`/`pktChanged_i` write port.

---
 rtl/i2s_pkg.sv | 16 +
 rtl/i2s_rx_deser.sv | 75 +++++++
 tb/tb_i2s_rx_deser.sv | 139 +++++++++++++
 3 files changed

// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared I2S sample width, packet type and receiver state encoding
package i2s_pkg;

    localparam int PKT_WIDTH = 16;

    typedef logic [PKT_WIDTH-1:0] pkt_t;

    typedef enum logic {
        UNSYNC = 1'b0,
        SYNC   = 1'b1
    } rx_state_t;

    localparam logic [4:0] CNT_LAST = 5'(PKT_WIDTH - 1);
    localparam logic [4:0] CNT_MAX  = 5'd31;

endpackage

// File: rtl/i2s_rx_deser.sv
// rtl/i2s_rx_deser.sv - I2S receive deserializer, BCLK domain, one-cycle valid per completed sample
module i2s_rx_deser
    import i2s_pkg::*;
(
    input  logic                 clkI2SBit_i,
    input  logic                 rstI2S_n_i,
    input  logic                 sdI2S_i,
    input  logic                 wsI2S_i,
    input  logic                 errClr_i,
    output logic [PKT_WIDTH-1:0] pktI2S_o,
    output logic                 pktValidI2S_o,
    output logic                 pktRight_o,
    output logic                 framingErr_o
);

    rx_state_t              r_state;
    logic                   r_ws_s;
    logic [PKT_WIDTH-2:0]   r_sh;
    logic [4:0]             r_cnt;
    logic [PKT_WIDTH-1:0]   r_pkt;
    logic                   r_valid;
    logic                   r_right;
    logic                   r_err;
    logic                   w_ws_edge;

    // The bit sampled on a WS transition edge is the LSB of the word just ending.
    assign w_ws_edge = (wsI2S_i != r_ws_s);

    always_ff @(posedge clkI2SBit_i or negedge rstI2S_n_i) begin
        if (!rstI2S_n_i) begin
            r_state <= UNSYNC;
            r_ws_s  <= 1'b0;
            r_sh    <= '0;
            r_cnt   <= '0;
            r_pkt   <= '0;
            r_valid <= 1'b0;
            r_right <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_ws_s  <= wsI2S_i;
            r_valid <= 1'b0;
            if (errClr_i) begin
                r_err <= 1'b0;
            end
            if (w_ws_edge) begin
                r_cnt <= '0;
                case (r_state)
                    UNSYNC: r_state <= SYNC;
                    SYNC: begin
                        if (r_cnt == CNT_LAST) begin
                            r_pkt   <= {r_sh, sdI2S_i};
                            r_right <= r_ws_s;
                            r_valid <= 1'b1;
                        end else begin
                            // Wrong length: drop the word; cnt reset realigns to the new word.
                            r_err <= 1'b1;
                        end
                    end
                    default: r_state <= UNSYNC;
                endcase
            end else begin
                r_sh <= {r_sh[PKT_WIDTH-3:0], sdI2S_i};
                if (r_cnt != CNT_MAX) begin
                    r_cnt <= r_cnt + 5'd1;
                end
            end
        end
    end

    assign pktI2S_o      = r_pkt;
    assign pktValidI2S_o = r_valid;
    assign pktRight_o    = r_right;
    assign framingErr_o  = r_err;

endmodule

// File: tb/tb_i2s_rx_deser.sv
// tb/tb_i2s_rx_deser.sv - directed table-driven bench for the I2S receive deserializer
module tb_i2s_rx_deser;
    import i2s_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        sd;
    logic        ws;
    logic        err_clr;
    logic [15:0] pkt;
    logic        pkt_valid;
    logic        pkt_right;
    logic        framing_err;

    int total;
    int bad;

    i2s_rx_deser dut (
        .clkI2SBit_i   (clk),
        .rstI2S_n_i    (rst_n),
        .sdI2S_i       (sd),
        .wsI2S_i       (ws),
        .errClr_i      (err_clr),
        .pktI2S_o      (pkt),
        .pktValidI2S_o (pkt_valid),
        .pktRight_o    (pkt_right),
        .framingErr_o  (framing_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ch;
        logic [31:0] data;
        int          n;
        int          clr;
        logic        exp_v;
        logic        exp_err;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive_bit(input logic w, input logic d, input logic c);
        @(negedge clk);
        ws      = w;
        sd      = d;
        err_clr = c;
        @(posedge clk);
        #1;
    endtask

    // clr: 0 none, 1 on the word's first bit, 2 on the word's LSB (transition) bit
    task automatic send_word(input logic ch, input logic [31:0] data, input int n,
                             input int clr, input logic exp_v, input logic exp_err);
        for (int i = n - 1; i >= 0; i--) begin
            drive_bit((i == 0) ? ~ch : ch, data[i],
                      ((clr == 1) && (i == n - 1)) || ((clr == 2) && (i == 0)));
            if (i == n - 1) chk("pulse_width", {31'b0, pkt_valid}, 32'd0);
        end
        chk("valid", {31'b0, pkt_valid}, {31'b0, exp_v});
        if (exp_v) begin
            chk("data", {16'b0, pkt}, {16'b0, data[15:0]});
            chk("right", {31'b0, pkt_right}, {31'b0, ch});
        end
        chk("framing_err", {31'b0, framing_err}, {31'b0, exp_err});
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        rst_n   = 1'b0;
        sd      = 1'b0;
        ws      = 1'b0;
        err_clr = 1'b0;

        tbl[0]  = '{1'b0, 32'h0000AAAA, 16, 0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 32'h00005555, 16, 0, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 32'h0000AAAA, 16, 0, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 32'h00005555, 16, 0, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 32'h00001234, 15, 0, 1'b0, 1'b1};
        tbl[5]  = '{1'b1, 32'h0000BEEF, 16, 1, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 32'h0009ABCD, 20, 2, 1'b0, 1'b1};
        tbl[7]  = '{1'b1, 32'h00008001, 16, 0, 1'b1, 1'b1};
        tbl[8]  = '{1'b0, 32'h00007FFF, 16, 1, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 32'h00000F0F, 16, 0, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 32'h00000123, 15, 0, 1'b0, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_pkt",   {16'b0, pkt},         32'd0);
        chk("rst_valid", {31'b0, pkt_valid},   32'd0);
        chk("rst_right", {31'b0, pkt_right},   32'd0);
        chk("rst_err",   {31'b0, framing_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 11; k++) begin
            send_word(tbl[k].ch, tbl[k].data, tbl[k].n, tbl[k].clr, tbl[k].exp_v, tbl[k].exp_err);
        end

        // Asynchronous reset in the middle of a right-channel word, away from any edge.
        for (int i = 0; i < 5; i++) drive_bit(1'b1, i[0], 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_pkt",   {16'b0, pkt},         32'd0);
        chk("async_rst_valid", {31'b0, pkt_valid},   32'd0);
        chk("async_rst_right", {31'b0, pkt_right},   32'd0);
        chk("async_rst_err",   {31'b0, framing_err}, 32'd0);
        ws = 1'b0;
        sd = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        send_word(1'b0, 32'h00001357, 16, 0, 1'b0, 1'b0);
        send_word(1'b1, 32'h00002468, 16, 0, 1'b1, 1'b0);
        send_word(1'b0, 32'h00004444, 16, 0, 1'b1, 1'b0);

        for (int i = 0; i < 32; i++) begin
            logic [15:0] v;
            v = 16'hAAAA + 16'(i) * 16'h1111;
            send_word(~i[0], {16'b0, v}, 16, 0, 1'b1, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
